ble_uart_rx: RTL and testbench

//  Receive half of the BLE PMOD (JA) UART link: deserialises 8N1 frames from the module's TXD pin (JA3),

---
 rtl/ble_uart_pkg.sv | 16 +
 rtl/ble_uart_rx_sync_fifo.sv | 54 +++++
 rtl/ble_uart_rx.sv | 166 ++++++++++++++++
 tb/tb_ble_uart_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_uart_pkg.sv
// Shared types and helpers for the BLE PMOD UART receive path.
package ble_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ble_rx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/ble_uart_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Status flags, accept qualifiers and head-of-queue output.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ble_uart_rx.sv
// BLE PMOD UART receiver: 8N1 deserialiser, receive FIFO, RTS flow control
// and sticky error flags.
module ble_uart_rx
  import ble_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RTS_THRESH  = 12
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              i_rxd,
  output logic                              o_rts_n,
  output logic [7:0]                        o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_frame_err,
  output logic                              o_overrun,
  input  logic                              i_clr_err
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ_HZ, BAUD);
  localparam int unsigned TW      = $clog2(BIT_CYC);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYC / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RTS_LEVEL = CW'(RTS_THRESH);

  if (BIT_CYC < 4) begin : g_bad_baud
    $error("ble_uart_rx: bit period below 4 clock cycles");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ble_uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (RTS_THRESH < 1 || RTS_THRESH > FIFO_DEPTH) begin : g_bad_thresh
    $error("ble_uart_rx: RTS_THRESH out of range");
  end

  logic          sync_1;
  logic          rx_s;
  logic          live_1;
  logic          live_2;
  logic          rx_prev;
  ble_rx_state_t state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          expire;
  logic          fall;
  logic          push;
  logic          stop_bad;
  logic          pop;
  logic          overrun_set;
  logic          fifo_full;
  logic          fifo_empty;

  // rx_prev only counts as high once the synchroniser holds a real line
  // sample (live_2), so a line held low across reset release is never
  // mistaken for a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_1  <= 1'b1;
      rx_s    <= 1'b1;
      live_1  <= 1'b0;
      live_2  <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      sync_1  <= i_rxd;
      rx_s    <= sync_1;
      live_1  <= 1'b1;
      live_2  <= live_1;
      rx_prev <= rx_s & live_2;
    end
  end

  // Frame-level decode of the synchronised line.
  always_comb begin
    o_valid     = ~fifo_empty;
    expire      = (timer == '0);
    fall        = rx_prev & ~rx_s;
    push        = (state == STOP) & expire & rx_s;
    stop_bad    = (state == STOP) & expire & ~rx_s;
    pop         = o_valid & i_ready;
    overrun_set = push & fifo_full & ~pop;
  end

  // Receive FSM with mid-bit sampling timer and LSB-first shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            timer <= HALF_LOAD;
          end
        end
        START: begin
          if (!expire) begin
            timer <= timer - TW'(1);
          end else if (!rx_s) begin
            state   <= DATA;
            timer   <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!expire) begin
            timer <= timer - TW'(1);
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            timer <= FULL_LOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (!expire) timer <= timer - TW'(1);
          else         state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= stop_bad    | (o_frame_err & ~i_clr_err);
      o_overrun   <= overrun_set | (o_overrun   & ~i_clr_err);
    end
  end

  // RTS follows occupancy one cycle behind the count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) o_rts_n <= 1'b1;
    else       o_rts_n <= (o_count >= RTS_LEVEL);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

endmodule

// File: tb/tb_ble_uart_rx.sv
// Scoreboard bench for ble_uart_rx: a UART line model issues frames and
// queues the bytes expected to be stored; a monitor pops and compares every
// byte the DUT hands over.
module tb_ble_uart_rx;

  localparam int unsigned CLK_HZ    = 2_000_000;
  localparam int unsigned BAUD_R    = 100_000;
  localparam int unsigned BC        = 20;               // (2e6 + 5e4) / 1e5
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned THRESH    = 12;
  localparam int unsigned STOP_EDGE = 3 + BC / 2 + 9 * BC; // posedge of stop sample after start edge

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_rxd = 1'b1;
  logic       i_ready = 1'b0;
  logic       i_clr_err = 1'b0;
  logic       o_rts_n;
  logic [7:0] o_data;
  logic       o_valid;
  logic [4:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  logic [7:0]  exp_q [$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  ble_uart_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R),
    .FIFO_DEPTH  (DEPTH),
    .RTS_THRESH  (THRESH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_rxd       (i_rxd),
    .o_rts_n     (o_rts_n),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called on a negedge; returns on a negedge with the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit store);
    if (store) exp_q.push_back(b);
    i_rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      repeat (BC) @(negedge clk);
    end
    i_rxd = stop_bit;
    repeat (BC) @(negedge clk);
    i_rxd = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_n(input int unsigned n);
    repeat (n) begin
      i_ready = 1'b1;
      @(negedge clk);
    end
    i_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
  endtask

  // Monitor: inputs change on negedge, so #1 later they are stable up to the next posedge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no byte at %0t", o_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {24'd0, o_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    idle(3);
    chk("rst_rts", o_rts_n, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_ovr", o_overrun, 0);
    rstn = 1'b1;
    idle(4);
    chk("rts_after_reset", o_rts_n, 0);

    // 1: single byte, exact valid latency
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 chk("t1_valid_early", o_valid, 0);
        @(posedge clk);
        #1;
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, 8'hA5);
        chk("t1_count", o_count, 1);
      end
    join
    pop_n(1);
    idle(1);
    chk("t1_valid_after_pop", o_valid, 0);

    // 2: short low glitch must not start a frame
    i_rxd = 1'b0;
    idle(5);
    i_rxd = 1'b1;
    idle(3 * BC);
    chk("t2_valid", o_valid, 0);
    chk("t2_count", o_count, 0);
    chk("t2_ferr", o_frame_err, 0);
    chk("t2_ovr", o_overrun, 0);

    // 3: bad stop bit with clear on the same cycle -> flag still set
    fork
      send_frame(8'h3C, 1'b0, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
      end
    join
    idle(2);
    chk("t3_ferr_set", o_frame_err, 1);
    chk("t3_count", o_count, 0);
    clr_pulse();
    idle(1);
    chk("t3_ferr_clr", o_frame_err, 0);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(2);
    chk("t3_data", o_data, 8'h11);
    pop_n(1);

    // 4: fill past threshold and capacity, then drain
    for (int i = 0; i < 11; i++) send_frame(8'(i), 1'b1, 1'b1);
    idle(3);
    chk("t4_count11", o_count, 11);
    chk("t4_rts_11", o_rts_n, 0);
    send_frame(8'h0B, 1'b1, 1'b1);
    idle(3);
    chk("t4_count12", o_count, 12);
    chk("t4_rts_12", o_rts_n, 1);
    for (int i = 12; i < 16; i++) send_frame(8'(i), 1'b1, 1'b1);
    idle(3);
    chk("t4_count16", o_count, 16);
    chk("t4_ovr_clear", o_overrun, 0);
    send_frame(8'h10, 1'b1, 1'b0);
    idle(3);
    chk("t4_ovr_set", o_overrun, 1);
    chk("t4_count_full", o_count, 16);
    chk("t4_head", o_data, 8'h00);
    pop_n(4);
    idle(2);
    chk("t4_rts_drain12", o_rts_n, 1);
    pop_n(1);
    idle(2);
    chk("t4_rts_drain11", o_rts_n, 0);
    pop_n(11);
    idle(1);
    chk("t4_empty", o_valid, 0);
    clr_pulse();
    idle(1);
    chk("t4_ovr_clr", o_overrun, 0);

    // 5: full FIFO, 17th byte lands on the cycle of a pop
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b1);
    idle(2);
    chk("t5_full", o_count, 16);
    fork
      send_frame(8'h30, 1'b1, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
      end
    join
    idle(2);
    chk("t5_count", o_count, 16);
    chk("t5_ovr", o_overrun, 0);
    pop_n(16);
    idle(1);
    chk("t5_drained", o_count, 0);

    // 6: reset mid-frame (bit 4 of 0x5A), released while line is low
    i_rxd = 1'b0;
    idle(BC);
    for (int i = 0; i < 4; i++) begin
      i_rxd = (8'h5A >> i) & 8'h01;
      idle(BC);
    end
    i_rxd = 1'b1;                      // bit 4
    idle(BC / 2);
    rstn = 1'b0;
    idle(BC / 2);
    i_rxd = 1'b0;                      // bit 5
    idle(2);
    chk("t6_rst_rts", o_rts_n, 1);
    chk("t6_rst_valid", o_valid, 0);
    idle(BC / 2 - 2);
    rstn = 1'b1;
    idle(BC);
    i_rxd = 1'b1;
    idle(3 * BC);
    chk("t6_no_byte", o_valid, 0);
    chk("t6_count", o_count, 0);
    chk("t6_ferr", o_frame_err, 0);
    chk("t6_rts", o_rts_n, 0);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(2);
    chk("t6_data", o_data, 8'hC3);
    pop_n(1);
    idle(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
